// File: rtl/read_controller_sdram_pkg.sv
// ============================================================================
// Module  : read_controller_sdram_pkg
// Purpose : Shared FSM encoding and frame-buffer geometry for the SDRAM pixel path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package read_controller_sdram_pkg;

  localparam int FRAME_WIDTH_DEFAULT  = 640;
  localparam int FRAME_HEIGHT_DEFAULT = 480;

  // Wrap boundary shared by the read and write sides of the frame buffer.
  localparam int BoundarySDRAM = FRAME_WIDTH_DEFAULT * FRAME_HEIGHT_DEFAULT * 2;
  localparam int HeadAddrWidth = $clog2(BoundarySDRAM);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    RECEIVE = 2'd2
  } rd_state_e;

  function automatic int boundary_sdram(input int width, input int height);
    return width * height * 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/read_controller_sdram_if.sv
// ============================================================================
// Module  : read_controller_sdram_if
// Purpose : Pixel consumer and SDRAM read handshake bundle of the read controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface read_controller_sdram_if #(
  parameter int PixelBitWidth     = 16,
  parameter int AddressWidthSDRAM = 24
);

  logic                         i_frame_start;
  logic                         i_pixel_req;
  logic [PixelBitWidth-1:0]     o_pixel;
  logic                         o_pixel_valid;
  logic                         o_underflow;
  logic                         o_sdram_rd_req;
  logic [AddressWidthSDRAM-1:0] o_sdram_addr;
  logic                         i_sdram_ack;
  logic                         i_sdram_valid_rd;
  logic [PixelBitWidth-1:0]     i_sdram_data;
  logic                         o_busy_rd;

  modport master (
    input  i_frame_start, i_pixel_req, i_sdram_ack, i_sdram_valid_rd, i_sdram_data,
    output o_pixel, o_pixel_valid, o_underflow, o_sdram_rd_req, o_sdram_addr, o_busy_rd
  );

  modport slave (
    output i_frame_start, i_pixel_req, i_sdram_ack, i_sdram_valid_rd, i_sdram_data,
    input  o_pixel, o_pixel_valid, o_underflow, o_sdram_rd_req, o_sdram_addr, o_busy_rd
  );

endinterface

`default_nettype wire

// File: rtl/read_controller_sdram_pixel_fifo_fwft.sv
// ============================================================================
// Module  : pixel_fifo_fwft
// Purpose : First-word-fall-through pixel FIFO with synchronous flush.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pixel_fifo_fwft #(
  parameter  int Width = 16,
  parameter  int Depth = 16,
  localparam int PtrW  = $clog2(Depth),
  localparam int CntW  = $clog2(Depth + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  count_o
);

  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [CntW-1:0] CntDepth = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q;
  logic [PtrW-1:0]  wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = pop_i && (count_q != '0);
  assign w_push = push_i && (count_q != CntDepth);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PtrOne;
      end
      if (w_pop) rd_ptr_q <= rd_ptr_q + PtrOne;
      if (w_push && !w_pop)      count_q <= count_q + CntOne;
      else if (w_pop && !w_push) count_q <= count_q - CntOne;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/read_controller_sdram.sv
// ============================================================================
// Module  : read_controller_sdram
// Purpose : Burst-reads the frame buffer from SDRAM and serves pixels to scan-out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module read_controller_sdram
  import read_controller_sdram_pkg::*;
#(
  parameter int FrameWidth        = FRAME_WIDTH_DEFAULT,
  parameter int FrameHeight       = FRAME_HEIGHT_DEFAULT,
  parameter int BurstLengthSDRAM  = 8,
  parameter int PixelBitWidth     = 16,
  parameter int AddressWidthSDRAM = 24,
  parameter int FifoDepth         = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  read_controller_sdram_if.master bus
);

  localparam int FrameBoundary = boundary_sdram(FrameWidth, FrameHeight);
  localparam int HeadW         = $clog2(FrameBoundary);
  localparam int CntW          = $clog2(FifoDepth + 1);
  localparam int BurstW        = $clog2(BurstLengthSDRAM + 1);

  localparam logic [HeadW:0]    HeadStep  = (HeadW + 1)'(BurstLengthSDRAM);
  localparam logic [HeadW:0]    HeadWrap  = (HeadW + 1)'(FrameBoundary);
  localparam logic [CntW-1:0]   BurstCnt  = CntW'(BurstLengthSDRAM);
  localparam logic [CntW-1:0]   DepthCnt  = CntW'(FifoDepth);
  localparam logic [CntW-1:0]   CntOne    = CntW'(1);
  localparam logic [BurstW-1:0] BurstLast = BurstW'(BurstLengthSDRAM);
  localparam logic [BurstW-1:0] BurstOne  = BurstW'(1);

  rd_state_e                    state_q;
  logic [HeadW-1:0]             head_q;
  logic [AddressWidthSDRAM-1:0] addr_q;
  logic                         rd_req_q;
  logic                         underflow_q;
  logic [CntW-1:0]              inflight_q;
  logic [BurstW-1:0]            word_cnt_q;
  logic                         drain_q;

  logic [CntW-1:0]  w_count;
  logic [CntW-1:0]  w_free;
  logic [HeadW:0]   w_head_sum;
  logic [HeadW-1:0] w_head_d;
  logic             w_push;
  logic             w_pop;
  logic             w_last_word;

  // Free space counts words already reserved by an outstanding burst.
  assign w_free      = DepthCnt - w_count - inflight_q;
  assign w_head_sum  = {1'b0, head_q} + HeadStep;
  assign w_head_d    = (w_head_sum == HeadWrap) ? '0 : w_head_sum[HeadW-1:0];
  assign w_last_word = (word_cnt_q + BurstOne) == BurstLast;
  assign w_push      = (state_q == RECEIVE) && bus.i_sdram_valid_rd && !drain_q && !bus.i_frame_start;
  assign w_pop       = bus.i_pixel_req && (w_count != '0) && !bus.i_frame_start;

  pixel_fifo_fwft #(
    .Width (PixelBitWidth),
    .Depth (FifoDepth)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push_i  (w_push),
    .data_i  (bus.i_sdram_data),
    .pop_i   (w_pop),
    .flush_i (bus.i_frame_start),
    .data_o  (bus.o_pixel),
    .count_o (w_count)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      head_q      <= '0;
      addr_q      <= '0;
      rd_req_q    <= 1'b0;
      underflow_q <= 1'b0;
      inflight_q  <= '0;
      word_cnt_q  <= '0;
      drain_q     <= 1'b0;
    end else begin
      underflow_q <= bus.i_pixel_req && (w_count == '0);
      if (bus.i_frame_start) head_q <= '0;
      case (state_q)
        IDLE: begin
          if (!bus.i_frame_start && (w_free >= BurstCnt)) begin
            state_q    <= REQUEST;
            rd_req_q   <= 1'b1;
            addr_q     <= AddressWidthSDRAM'(head_q);
            inflight_q <= inflight_q + BurstCnt;
          end
        end
        REQUEST: begin
          if (bus.i_frame_start) begin
            state_q    <= IDLE;
            rd_req_q   <= 1'b0;
            inflight_q <= '0;
          end else if (bus.i_sdram_ack) begin
            state_q    <= RECEIVE;
            rd_req_q   <= 1'b0;
            head_q     <= w_head_d;
            word_cnt_q <= '0;
          end
        end
        RECEIVE: begin
          // A restart mid-burst still has to absorb the rest of the burst.
          if (bus.i_frame_start) begin
            drain_q    <= 1'b1;
            inflight_q <= '0;
          end
          if (bus.i_sdram_valid_rd) begin
            word_cnt_q <= word_cnt_q + BurstOne;
            if (w_push) inflight_q <= inflight_q - CntOne;
            if (w_last_word) begin
              state_q <= IDLE;
              drain_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_sdram_rd_req = rd_req_q;
  assign bus.o_sdram_addr   = addr_q;
  assign bus.o_underflow    = underflow_q;
  assign bus.o_pixel_valid  = (w_count != '0);
  assign bus.o_busy_rd      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_read_controller_sdram.sv
// ============================================================================
// Module  : tb_read_controller_sdram
// Purpose : Randomised and directed checks of the SDRAM read controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_read_controller_sdram;

  localparam int BL     = 8;
  localparam int DEPTH  = 16;
  localparam int BOUND  = 640 * 480 * 2;
  localparam int W2     = 8;
  localparam int H2     = 2;
  localparam int BOUND2 = W2 * H2 * 2;

  localparam int P_IDLE = 0;
  localparam int P_REQ  = 1;
  localparam int P_RCV  = 2;

  localparam int M_DIRECTED = 0;
  localparam int M_AUTO     = 1;
  localparam int M_RANDOM   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  read_controller_sdram_if bus ();
  read_controller_sdram_if bus2 ();

  read_controller_sdram u_dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  read_controller_sdram #(
    .FrameWidth  (W2),
    .FrameHeight (H2)
  ) u_wrap (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the main instance ----------------
  logic [15:0] m_q[$];
  int          m_phase = P_IDLE;
  int          m_head  = 0;
  int          m_res   = 0;
  int          m_got   = 0;
  bit          m_drain = 1'b0;
  bit          e_req   = 1'b0;
  bit          e_under = 1'b0;
  int          e_addr  = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_phase = P_IDLE; m_head = 0; m_res = 0; m_got = 0; m_drain = 1'b0;
      e_req = 1'b0; e_under = 1'b0; e_addr = 0;
    end else begin
      int qs;
      qs = m_q.size();
      e_under = bus.i_pixel_req && (qs == 0);
      if (bus.i_frame_start) begin
        m_q.delete();
        m_head = 0;
        if (m_phase == P_REQ) begin
          m_phase = P_IDLE; e_req = 1'b0; m_res = 0;
        end else if (m_phase == P_RCV) begin
          m_drain = 1'b1; m_res = 0;
          if (bus.i_sdram_valid_rd) begin
            m_got++;
            if (m_got == BL) begin m_phase = P_IDLE; m_drain = 1'b0; end
          end
        end
      end else begin
        if (bus.i_pixel_req && qs > 0) void'(m_q.pop_front());
        if (m_phase == P_IDLE) begin
          if (DEPTH - qs - m_res >= BL) begin
            m_phase = P_REQ; m_res = BL; e_req = 1'b1; e_addr = m_head;
          end
        end else if (m_phase == P_REQ) begin
          if (bus.i_sdram_ack) begin
            m_head  = (m_head + BL == BOUND) ? 0 : m_head + BL;
            m_got   = 0; m_phase = P_RCV; e_req = 1'b0;
          end
        end else begin
          if (bus.i_sdram_valid_rd) begin
            m_got++;
            if (!m_drain) begin m_q.push_back(bus.i_sdram_data); m_res--; end
            if (m_got == BL) begin m_phase = P_IDLE; m_drain = 1'b0; end
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("rd_req", {31'd0, bus.o_sdram_rd_req}, {31'd0, e_req});
    if (e_req) chk("sdram_addr", {8'd0, bus.o_sdram_addr}, e_addr);
    chk("pixel_valid", {31'd0, bus.o_pixel_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) chk("pixel", {16'd0, bus.o_pixel}, {16'd0, m_q[0]});
    chk("underflow", {31'd0, bus.o_underflow}, {31'd0, e_under});
    chk("busy", {31'd0, bus.o_busy_rd}, {31'd0, m_phase != P_IDLE});
  end

  // ---------------- stimulus ----------------
  int mode    = M_DIRECTED;
  int pop_pct = 50;
  int pend1   = 0;
  int pend2   = 0;
  int bursts  = 0;
  int exp2    = 0;
  int nwrap   = 0;
  int wrap_seen[6];

  task automatic tick();
    if (pend2 > 0) begin
      bus2.i_sdram_valid_rd = 1'b1;
      bus2.i_sdram_data     = 16'($urandom);
      pend2--;
    end else begin
      bus2.i_sdram_valid_rd = 1'b0;
    end
    bus2.i_sdram_ack = bus2.o_sdram_rd_req;
    if (bus2.o_sdram_rd_req) begin
      chk("wrap_addr", {8'd0, bus2.o_sdram_addr}, exp2);
      if (nwrap < 6) begin wrap_seen[nwrap] = int'(bus2.o_sdram_addr); nwrap++; end
      exp2  = (exp2 + BL == BOUND2) ? 0 : exp2 + BL;
      pend2 = BL;
    end
    if (mode == M_AUTO) begin
      if (pend1 > 0) begin
        bus.i_sdram_valid_rd = 1'b1;
        bus.i_sdram_data     = 16'($urandom);
        pend1--;
      end else begin
        bus.i_sdram_valid_rd = 1'b0;
      end
      bus.i_sdram_ack = bus.o_sdram_rd_req;
      if (bus.o_sdram_rd_req) begin bursts++; pend1 = BL; end
    end else if (mode == M_RANDOM) begin
      bus.i_sdram_ack      = ($urandom_range(0, 2) == 0);
      bus.i_sdram_valid_rd = ($urandom_range(0, 1) == 1);
      bus.i_sdram_data     = 16'($urandom);
      bus.i_pixel_req      = ($urandom_range(0, 99) < pop_pct);
      bus.i_frame_start    = ($urandom_range(0, 49) == 0);
    end
    @(negedge clk);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 200; i++) begin
      if (bus.o_sdram_rd_req) break;
      tick();
    end
    if (!bus.o_sdram_rd_req) chk("req_wait", {31'd0, bus.o_sdram_rd_req}, 32'd1);
  endtask

  task automatic clear_inputs();
    bus.i_frame_start = 1'b0; bus.i_pixel_req = 1'b0; bus.i_sdram_ack = 1'b0;
    bus.i_sdram_valid_rd = 1'b0; bus.i_sdram_data = '0;
    bus2.i_frame_start = 1'b0; bus2.i_pixel_req = 1'b1; bus2.i_sdram_ack = 1'b0;
    bus2.i_sdram_valid_rd = 1'b0; bus2.i_sdram_data = '0;
    pend1 = 0; pend2 = 0; exp2 = 0;
  endtask

  initial begin
    int wrap_exp[6];
    logic [15:0] p0;
    wrap_exp = '{0, 8, 16, 24, 0, 8};
    clear_inputs();
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_rd_req", {31'd0, bus.o_sdram_rd_req}, 32'd0);
    chk("rst_addr", {8'd0, bus.o_sdram_addr}, 32'd0);
    chk("rst_pixel", {16'd0, bus.o_pixel}, 32'd0);
    chk("rst_valid", {31'd0, bus.o_pixel_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.o_busy_rd}, 32'd0);

    // First burst: ack after two cycles, words 1..8.
    tick();
    chk("t1_req_latency", {31'd0, bus.o_sdram_rd_req}, 32'd1);
    wait_req();
    chk("t1_addr", {8'd0, bus.o_sdram_addr}, 32'd0);
    tick(); tick();
    bus.i_sdram_ack = 1'b1; tick(); bus.i_sdram_ack = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      bus.i_sdram_valid_rd = 1'b1; bus.i_sdram_data = 16'(k);
      tick();
      if (k == 1) chk("t1_first_pixel", {16'd0, bus.o_pixel}, 32'd1);
    end
    bus.i_sdram_valid_rd = 1'b0;
    wait_req();
    chk("t1_second_addr", {8'd0, bus.o_sdram_addr}, 32'd8);
    for (int k = 1; k <= 8; k++) begin
      chk("t1_pop_order", {16'd0, bus.o_pixel}, k);
      bus.i_pixel_req = 1'b1; tick();
    end
    bus.i_pixel_req = 1'b0;
    bus.i_frame_start = 1'b1; tick(); bus.i_frame_start = 1'b0;
    chk("t1_withdraw", {31'd0, bus.o_sdram_rd_req}, 32'd0);

    // Two bursts fill the FIFO; the third waits for eight pops.
    mode = M_AUTO; bursts = 0;
    repeat (80) tick();
    chk("t2_two_bursts", bursts, 32'd2);
    bus.i_pixel_req = 1'b1; repeat (7) tick(); bus.i_pixel_req = 1'b0;
    repeat (30) tick();
    chk("t2_held_at_seven", bursts, 32'd2);
    bus.i_pixel_req = 1'b1; tick(); bus.i_pixel_req = 1'b0;
    repeat (30) tick();
    chk("t2_third_burst", bursts, 32'd3);
    mode = M_DIRECTED;
    bus.i_sdram_ack = 1'b0; bus.i_sdram_valid_rd = 1'b0;
    bus.i_frame_start = 1'b1; tick(); bus.i_frame_start = 1'b0;
    chk("t2_flushed", {31'd0, bus.o_pixel_valid}, 32'd0);

    // Restart after 3 of 8 words: remaining 5 dropped.
    wait_req();
    chk("t4_addr", {8'd0, bus.o_sdram_addr}, 32'd0);
    bus.i_sdram_ack = 1'b1; tick(); bus.i_sdram_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.i_sdram_valid_rd = 1'b1; bus.i_sdram_data = 16'(16'hA1 + k); tick();
    end
    bus.i_sdram_valid_rd = 1'b0; bus.i_frame_start = 1'b1; tick(); bus.i_frame_start = 1'b0;
    chk("t4_flush_empty", {31'd0, bus.o_pixel_valid}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      bus.i_sdram_valid_rd = 1'b1; bus.i_sdram_data = 16'(16'hB0 + k); tick();
    end
    bus.i_sdram_valid_rd = 1'b0;
    chk("t4_drained_idle", {31'd0, bus.o_busy_rd}, 32'd0);
    chk("t4_drained_empty", {31'd0, bus.o_pixel_valid}, 32'd0);
    wait_req();
    chk("t4_restart_addr", {8'd0, bus.o_sdram_addr}, 32'd0);

    // Underflow on an empty FIFO.
    p0 = bus.o_pixel;
    bus.i_pixel_req = 1'b1; tick(); bus.i_pixel_req = 1'b0;
    chk("t5_underflow", {31'd0, bus.o_underflow}, 32'd1);
    chk("t5_pixel_hold", {16'd0, bus.o_pixel}, {16'd0, p0});
    chk("t5_still_empty", {31'd0, bus.o_pixel_valid}, 32'd0);
    tick();
    chk("t5_pulse_end", {31'd0, bus.o_underflow}, 32'd0);

    // Asynchronous reset in the middle of a burst.
    bus.i_sdram_ack = 1'b1; tick(); bus.i_sdram_ack = 1'b0;
    bus.i_sdram_valid_rd = 1'b1; bus.i_sdram_data = 16'h5A5A; tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rd_req", {31'd0, bus.o_sdram_rd_req}, 32'd0);
    chk("t6_addr", {8'd0, bus.o_sdram_addr}, 32'd0);
    chk("t6_pixel", {16'd0, bus.o_pixel}, 32'd0);
    chk("t6_valid", {31'd0, bus.o_pixel_valid}, 32'd0);
    chk("t6_busy", {31'd0, bus.o_busy_rd}, 32'd0);
    chk("t6_underflow", {31'd0, bus.o_underflow}, 32'd0);
    clear_inputs();
    tick(); tick();
    rst_n = 1'b1;
    wait_req();
    chk("t6_post_reset_addr", {8'd0, bus.o_sdram_addr}, 32'd0);

    for (int k = 0; k < 6; k++) chk("wrap_sequence", wrap_seen[k], wrap_exp[k]);

    // Randomised traffic against the model.
    mode = M_RANDOM;
    pop_pct = 25; repeat (2500) tick();
    pop_pct = 80; repeat (2500) tick();
    mode = M_DIRECTED;
    clear_inputs();
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
